floppy_track_buffer: RTL and testbench
======================================

Name: floppy_track_buffer

Overview:
- Loads one whole Apple II floppy track (13 × 512-byte sectors, 6656 bytes) from the SD block interface into a one-track RAM whenever the drive's track changes or a new image is mounted.
- The disk controller reads the buffered track byte-by-byte through a dedicated read port.
- Sits between the SD sector-transfer interface (channel 0) and the apple2_top floppy controller.
- Also stalls the CPU (cpu_wait) while a track is loading.

Parameters:
- SECTORS_PER_TRACK, 13, sectors fetched per track.
- ADDR_W, 14, one-track RAM address width (16384 × 8).
- TRACK_W, 6, width of the track number.

Ports:
- CLK_VIDEO  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- track  in  6  current head track from the controller.
- img_mounted  in  1  pulse/level: image (re)mounted on drive 0.
- img_size  in  64  mounted image size in bytes; 0 means no image.
- sd_ack  in  1  SD transfer acknowledge, high for the duration of one sector transfer.
- sd_buff_addr  in  9  byte offset within the sector being transferred.
- sd_buff_dout  in  8  byte from SD.
- sd_buff_wr  in  1  byte write strobe from SD.
- sd_lba  out  32  sector LBA requested.
- sd_rd  out  1  read request.
- sd_wr  out  1  write request; constant 0 (no write-back).
- cpu_wait  out  1  CPU stall while a track loads.
- track_sec  out  4  sector index currently being filled.
- fd_track_addr  in  14  controller read address within the track.
- fd_data_in  out  8  registered read data.

Behaviour:
- Reset values: state=IDLE, sd_rd=0, sd_wr=0, cpu_wait=0, sd_lba=0, track_sec=0, cur_track=0, fdd_mounted=0, old_ack=0.
- fd_data_in is not reset; RAM contents are not reset.

Every cycle:
- old_ack <= sd_ack.
- fdd_mounted <= fdd_mounted | img_mounted, unless cleared below.

IDLE:
- Trigger when (cur_track != track) OR (fdd_mounted & ~img_mounted), i.e. the mount pulse has ended.
- On trigger: cur_track <= track and fdd_mounted <= 0.
- If img_size != 0 on trigger: track_sec <= 0, sd_lba <= 13*track (unsigned, zero-extended to 32 bits), sd_rd <= 1, cpu_wait <= 1, state <= LOAD.
- If img_size == 0 on trigger: stay in IDLE; the track change is absorbed and no load occurs.

LOAD:
- Rising edge of sd_ack (~old_ack & sd_ack):
  - sd_lba <= sd_lba + 1.
  - If track_sec >= 12, sd_rd <= 0.
- Falling edge of sd_ack (old_ack & ~sd_ack):
  - track_sec <= track_sec + 1.
  - If sd_rd == 0: state <= IDLE and cpu_wait <= 0.
- Result: exactly 13 sectors per load, LBAs 13*track … 13*track+12; the final track_sec is 13.
- A track change during LOAD is ignored until IDLE. It is then detected and a new load starts on the next cycle.
- Reset mid-LOAD aborts immediately; partial RAM data is kept.

RAM:
- 2^ADDR_W × 8, true dual-port, single clock.
- Port A write: address {1'b0, track_sec, sd_buff_addr}, enable sd_buff_wr & sd_ack, data sd_buff_dout.
- Port B read: address fd_track_addr, read-only; fd_data_in valid 1 cycle after the address is presented.
- Simultaneous write/read of the same address: port B returns the old data (read-before-write).
- Addresses ≥ 6656 are never written and read back whatever the RAM holds.

Decomposition:
- Package floppy_pkg: SECTORS_PER_TRACK=13, SECTOR_BYTES=512, TRACK_BYTES=6656, and a state enum {IDLE, LOAD}.
- One sub-module, track_dpram: parameterised data/address-width dual-port RAM with registered outputs.

Test Plan:
- Mount then track change: img_size=143360, img_mounted pulse, then track 0→3 → sd_rd=1 and cpu_wait=1 the next cycle, sd_lba=39. The SD model runs 13 ack pulses, sd_lba counts to 52, sd_rd falls on the 13th ack rise, and cpu_wait falls on the 13th ack fall.
- Data path: SD model writes byte = (sector*7 + offset) & 0xFF for each sector. Read fd_track_addr=0x0205 → fd_data_in=0x0C one cycle later; read 6655 → ((12*7 + 511) & 0xFF) = 0x53.
- No image: img_size=0, track 0→5 → sd_rd stays 0, cpu_wait stays 0, state stays IDLE. A later nonzero img_size with no further track change or remount → still no load.
- Remount on the same track: img_mounted high 3 cycles, then low → the load starts the cycle after the fall, sd_lba=13*track.
- Reset mid-load: assert reset after 4 sectors → sd_rd=0, cpu_wait=0 the next cycle, state IDLE, sd_wr stays 0 throughout.
- Track change during LOAD: track 3→4 at sector 6 → the load finishes at LBA 51 → IDLE one cycle → new load starting at sd_lba=52.

Source files
------------

// File: rtl/floppy_track_buffer_pkg.sv
// Shared constants and types for the floppy track buffer: track geometry,
// loader FSM state encoding and the track-to-LBA mapping.
package floppy_pkg;

  localparam int SECTORS_PER_TRACK = 13;
  localparam int SECTOR_BYTES      = 512;
  localparam int SECTOR_ADDR_W     = 9;
  localparam int TRACK_BYTES       = SECTORS_PER_TRACK * SECTOR_BYTES;  // 6656

  // Loader states: waiting for a trigger, or pulling sectors from SD.
  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  // First LBA of a track: the image is a flat array of fixed-size tracks.
  function automatic logic [31:0] track_first_lba(input logic [31:0] track_num,
                                                  input int          sectors);
    return track_num * 32'(sectors);
  endfunction

endpackage

// File: rtl/floppy_track_buffer_dpram.sv
// Single-clock dual-port RAM: port A write-only, port B read-only with a
// registered output. A read that collides with a write to the same address
// returns the previous contents.
module track_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] din_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic [DATA_W-1:0] dout_b_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Port A write and port B registered read share one clocked process.
  // NOTE: the array and the read register are deliberately left without a
  // reset so the storage maps onto block RAM; the non-blocking write means the
  // same-edge read still samples the old word (read-before-write).
  always_ff @(posedge clk_i) begin
    if (we_a_i) begin
      mem_q[addr_a_i] <= din_a_i;
    end
    dout_b_o <= mem_q[addr_b_i];
  end

endmodule

// File: rtl/floppy_track_buffer.sv
// Whole-track loader for the Apple II floppy: whenever the head moves to a new
// track or a disk image is mounted, fetch all sectors of that track from the
// SD block interface into a one-track RAM, stalling the CPU meanwhile. The
// floppy controller reads the buffered track through a dedicated read port.
module floppy_track_buffer #(
  parameter int SECTORS_PER_TRACK = floppy_pkg::SECTORS_PER_TRACK,
  parameter int ADDR_W            = 14,
  parameter int TRACK_W           = 6
) (
  input  logic               CLK_VIDEO,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic [63:0]        img_size,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic               cpu_wait,
  output logic [3:0]         track_sec,
  input  logic [ADDR_W-1:0]  fd_track_addr,
  output logic [7:0]         fd_data_in
);

  import floppy_pkg::*;

  localparam logic [3:0] LAST_SEC = 4'(SECTORS_PER_TRACK - 1);

  state_e             state_q;
  logic [TRACK_W-1:0] cur_track_q;
  logic               fdd_mounted_q;
  logic               old_ack_q;
  logic [31:0]        sd_lba_q;
  logic               sd_rd_q;
  logic               cpu_wait_q;
  logic [3:0]         track_sec_q;

  logic               ack_rise;
  logic               ack_fall;
  logic               load_trigger;
  logic [31:0]        first_lba_d;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;

  // Edge detection on the SD acknowledge, one per sector transfer.
  assign ack_rise = ~old_ack_q & sd_ack;
  assign ack_fall = old_ack_q & ~sd_ack;

  // A new load is wanted when the head moved, or once a mount pulse has ended.
  assign load_trigger = (cur_track_q != track) | (fdd_mounted_q & ~img_mounted);

  assign first_lba_d = track_first_lba(32'(track), SECTORS_PER_TRACK);

  // Loader FSM; all outputs toward SD and the CPU are registered here.
  // NOTE: every state register is assigned with <= so all of them update from
  // the same pre-edge values, regardless of statement order in this block.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_track_q   <= '0;
      fdd_mounted_q <= 1'b0;
      old_ack_q     <= 1'b0;
      sd_lba_q      <= '0;
      sd_rd_q       <= 1'b0;
      cpu_wait_q    <= 1'b0;
      track_sec_q   <= '0;
    end else begin
      old_ack_q     <= sd_ack;
      fdd_mounted_q <= fdd_mounted_q | img_mounted;

      unique case (state_q)
        IDLE: begin
          if (load_trigger) begin
            cur_track_q   <= track;
            fdd_mounted_q <= 1'b0;
            // With no image mounted the track change is simply absorbed.
            if (img_size != 64'd0) begin
              track_sec_q <= '0;
              sd_lba_q    <= first_lba_d;
              sd_rd_q     <= 1'b1;
              cpu_wait_q  <= 1'b1;
              state_q     <= LOAD;
            end
          end
        end

        LOAD: begin
          // Each acknowledged sector advances the LBA; the request is dropped
          // as soon as the last sector of the track has been accepted.
          if (ack_rise) begin
            sd_lba_q <= sd_lba_q + 32'd1;
            if (track_sec_q >= LAST_SEC) begin
              sd_rd_q <= 1'b0;
            end
          end
          // End of a sector transfer: move to the next RAM slot, and finish
          // once no further request is outstanding.
          if (ack_fall) begin
            track_sec_q <= track_sec_q + 4'd1;
            if (!sd_rd_q) begin
              cpu_wait_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = 1'b0;
  assign cpu_wait  = cpu_wait_q;
  assign track_sec = track_sec_q;

  // SD bytes land at sector slot track_sec, offset sd_buff_addr.
  assign ram_we    = sd_buff_wr & sd_ack;
  assign ram_waddr = ADDR_W'({track_sec_q, sd_buff_addr});

  track_dpram #(
    .DATA_W (8),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i    (CLK_VIDEO),
    .we_a_i   (ram_we),
    .addr_a_i (ram_waddr),
    .din_a_i  (sd_buff_dout),
    .addr_b_i (fd_track_addr),
    .dout_b_o (fd_data_in)
  );

endmodule

// File: tb/tb_floppy_track_buffer.sv
// Directed bench for floppy_track_buffer: reset state, mount plus track-change
// load, buffered data readback, no-image behaviour, remount, reset mid-load
// and a track change while a load is in progress.
module tb_floppy_track_buffer;
  import floppy_pkg::*;

  logic        CLK_VIDEO = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  track = '0;
  logic        img_mounted = 1'b0;
  logic [63:0] img_size = '0;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0;
  logic        sd_buff_wr = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        cpu_wait;
  logic [3:0]  track_sec;
  logic [13:0] fd_track_addr = '0;
  logic [7:0]  fd_data_in;

  int checks = 0;
  int failures = 0;

  // Values captured by the SD model at each ack edge.
  logic [31:0] rise_lba;
  logic        rise_rd;
  logic        fall_wait;

  floppy_track_buffer dut (
    .CLK_VIDEO     (CLK_VIDEO),
    .reset         (reset),
    .track         (track),
    .img_mounted   (img_mounted),
    .img_size      (img_size),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_wr    (sd_buff_wr),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .cpu_wait      (cpu_wait),
    .track_sec     (track_sec),
    .fd_track_addr (fd_track_addr),
    .fd_data_in    (fd_data_in)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  // One SD sector transfer: ack high while bytes stream (512 with data,
  // otherwise a short 2-cycle pulse), then ack low for one cycle.
  task automatic sd_sector(input int sec, input bit with_data);
    int n;
    n = with_data ? 512 : 2;
    sd_ack     = 1'b1;
    sd_buff_wr = with_data;
    for (int off = 0; off < n; off++) begin
      sd_buff_addr = 9'(off);
      sd_buff_dout = 8'((sec * 7 + off) & 255);
      tick();
      if (off == 0) begin
        rise_lba = sd_lba;
        rise_rd  = sd_rd;
      end
    end
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    fall_wait = cpu_wait;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL reset_sd_rd: got %b want 0", sd_rd); end
    checks++; if (sd_wr !== 1'b0) begin failures++; $display("FAIL reset_sd_wr: got %b want 0", sd_wr); end
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL reset_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (sd_lba !== 32'd0) begin failures++; $display("FAIL reset_sd_lba: got %0d want 0", sd_lba); end
    checks++; if (track_sec !== 4'd0) begin failures++; $display("FAIL reset_track_sec: got %0d want 0", track_sec); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    reset = 1'b0;
    tick();
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL post_reset_idle: sd_rd got %b want 0", sd_rd); end
  endtask

  task automatic test_mount_load();
    img_size    = 64'd143360;
    img_mounted = 1'b1;
    tick();
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL mount_pulse_no_load: sd_rd got %b want 0", sd_rd); end
    img_mounted = 1'b0;
    track       = 6'd3;
    tick();
    checks++; if (sd_rd !== 1'b1) begin failures++; $display("FAIL load_start_sd_rd: got %b want 1", sd_rd); end
    checks++; if (cpu_wait !== 1'b1) begin failures++; $display("FAIL load_start_cpu_wait: got %b want 1", cpu_wait); end
    checks++; if (sd_lba !== 32'd39) begin failures++; $display("FAIL load_start_lba: got %0d want 39", sd_lba); end
    for (int s = 0; s < 13; s++) begin
      logic exp_rd;
      logic exp_wait;
      exp_rd   = (s < 12);
      exp_wait = (s < 12);
      sd_sector(s, 1'b1);
      checks++; if (rise_lba !== 32'(40 + s)) begin failures++; $display("FAIL load_rise_lba[%0d]: got %0d want %0d", s, rise_lba, 40 + s); end
      checks++; if (rise_rd !== exp_rd) begin failures++; $display("FAIL load_rise_rd[%0d]: got %b want %b", s, rise_rd, exp_rd); end
      checks++; if (fall_wait !== exp_wait) begin failures++; $display("FAIL load_fall_wait[%0d]: got %b want %b", s, fall_wait, exp_wait); end
    end
    checks++; if (track_sec !== 4'd13) begin failures++; $display("FAIL load_end_track_sec: got %0d want 13", track_sec); end
    checks++; if (sd_lba !== 32'd52) begin failures++; $display("FAIL load_end_lba: got %0d want 52", sd_lba); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL load_end_state: got %0d want IDLE", dut.state_q); end
    checks++; if (sd_wr !== 1'b0) begin failures++; $display("FAIL load_sd_wr: got %b want 0", sd_wr); end
  endtask

  task automatic test_data_path();
    logic [13:0] addrs [5];
    logic [7:0]  exps  [5];
    addrs = '{14'h0205, 14'd6655, 14'd0, 14'h01FF, 14'd1546};
    exps  = '{8'h0C,    8'h53,    8'h00, 8'hFF,    8'h1F};
    for (int i = 0; i < 5; i++) begin
      fd_track_addr = addrs[i];
      tick();
      checks++; if (fd_data_in !== exps[i]) begin failures++; $display("FAIL read[%0d]: got %02h want %02h", addrs[i], fd_data_in, exps[i]); end
    end
  endtask

  task automatic test_no_image();
    img_size = 64'd0;
    track    = 6'd5;
    tick();
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL noimg_sd_rd: got %b want 0", sd_rd); end
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL noimg_cpu_wait: got %b want 0", cpu_wait); end
    tick();
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL noimg_state: got %0d want IDLE", dut.state_q); end
    img_size = 64'd143360;
    repeat (3) tick();
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL noimg_late_size_sd_rd: got %b want 0", sd_rd); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL noimg_late_size_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_remount();
    img_mounted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL remount_held[%0d]: sd_rd got %b want 0", i, sd_rd); end
    end
    img_mounted = 1'b0;
    tick();
    checks++; if (sd_rd !== 1'b1) begin failures++; $display("FAIL remount_sd_rd: got %b want 1", sd_rd); end
    checks++; if (sd_lba !== 32'd65) begin failures++; $display("FAIL remount_lba: got %0d want 65", sd_lba); end
    checks++; if (cpu_wait !== 1'b1) begin failures++; $display("FAIL remount_cpu_wait: got %b want 1", cpu_wait); end
    for (int s = 0; s < 13; s++) sd_sector(s, 1'b0);
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL remount_end_wait: got %b want 0", cpu_wait); end
    checks++; if (sd_lba !== 32'd78) begin failures++; $display("FAIL remount_end_lba: got %0d want 78", sd_lba); end
  endtask

  task automatic test_reset_mid_load();
    track = 6'd6;
    tick();
    checks++; if (sd_lba !== 32'd78) begin failures++; $display("FAIL midreset_start_lba: got %0d want 78", sd_lba); end
    for (int s = 0; s < 4; s++) sd_sector(s, 1'b0);
    checks++; if (sd_rd !== 1'b1) begin failures++; $display("FAIL midreset_loading: sd_rd got %b want 1", sd_rd); end
    reset = 1'b1;
    track = 6'd3;
    tick();
    checks++; if (sd_rd !== 1'b0) begin failures++; $display("FAIL midreset_sd_rd: got %b want 0", sd_rd); end
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL midreset_cpu_wait: got %b want 0", cpu_wait); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL midreset_state: got %0d want IDLE", dut.state_q); end
    checks++; if (sd_wr !== 1'b0) begin failures++; $display("FAIL midreset_sd_wr: got %b want 0", sd_wr); end
    reset = 1'b0;
  endtask

  task automatic test_track_change_during_load();
    tick();
    checks++; if (sd_lba !== 32'd39) begin failures++; $display("FAIL tcl_start_lba: got %0d want 39", sd_lba); end
    for (int s = 0; s < 6; s++) sd_sector(s, 1'b0);
    track = 6'd4;
    for (int s = 6; s < 13; s++) begin
      sd_sector(s, 1'b0);
      if (s == 6) begin
        checks++; if (rise_lba !== 32'd46) begin failures++; $display("FAIL tcl_ignored_lba: got %0d want 46", rise_lba); end
      end
    end
    checks++; if (rise_lba !== 32'd52) begin failures++; $display("FAIL tcl_last_lba: got %0d want 52", rise_lba); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL tcl_idle: got %0d want IDLE", dut.state_q); end
    checks++; if (cpu_wait !== 1'b0) begin failures++; $display("FAIL tcl_idle_wait: got %b want 0", cpu_wait); end
    tick();
    checks++; if (sd_rd !== 1'b1) begin failures++; $display("FAIL tcl_reload_sd_rd: got %b want 1", sd_rd); end
    checks++; if (sd_lba !== 32'd52) begin failures++; $display("FAIL tcl_reload_lba: got %0d want 52", sd_lba); end
    checks++; if (track_sec !== 4'd0) begin failures++; $display("FAIL tcl_reload_sec: got %0d want 0", track_sec); end
    checks++; if (dut.state_q !== LOAD) begin failures++; $display("FAIL tcl_reload_state: got %0d want LOAD", dut.state_q); end
  endtask

  initial begin
    test_reset();
    test_mount_load();
    test_data_path();
    test_no_image();
    test_remount();
    test_reset_mid_load();
    test_track_change_during_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
